// File: rtl/grid_mem_arbiter_if.sv
// Grid RAM arbiter bus bundle.
// Groups the three ports of the shared single-port grid RAM: the renderer's read-only port,
// the game's req/ack port and the board-init control, plus the RAM-side signals.
// Modports:
//   slave  - the arbiter's view (drives acks, read data, RAM address/write)
//   master - the environment's view (renderer, game FSM, RAM model)
interface grid_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  // Renderer
  logic              video_en;
  logic [ADDR_W-1:0] video_addr;
  logic [DATA_W-1:0] video_data;
  // Game logic
  logic              game_req;
  logic              game_we;
  logic [ADDR_W-1:0] game_addr;
  logic [DATA_W-1:0] game_wdata;
  logic              game_ack;
  logic              game_err;
  logic [DATA_W-1:0] game_rdata;
  logic              game_rvalid;
  // Board init
  logic              init_start;
  logic              init_busy;
  // RAM
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  video_en, video_addr, game_req, game_we, game_addr, game_wdata, init_start,
           mem_rdata,
    output video_data, game_ack, game_err, game_rdata, game_rvalid, init_busy,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output video_en, video_addr, game_req, game_we, game_addr, game_wdata, init_start,
           mem_rdata,
    input  video_data, game_ack, game_err, game_rdata, game_rvalid, init_busy,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/grid_mem_arbiter.sv
// Tetris grid RAM arbiter.
// Shares one single-port grid RAM (COLS x ROWS cells) between the renderer (highest
// priority, read-only), the board-init sequencer and the game logic (req/ack, read/write).
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   bus   - grid_mem_arbiter_if.slave: video, game, init and RAM signals
module grid_mem_arbiter #(
  parameter int unsigned COLS       = 12,
  parameter int unsigned ROWS       = 20,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned AIR_VAL    = 0,
  parameter int unsigned BORDER_VAL = 8
) (
  input  logic                clk,
  input  logic                reset,
  grid_mem_arbiter_if.slave   bus
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  typedef enum logic [0:0] {StIdle, StInit} state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              video_own_q;
  logic              rvalid_q;
  logic              rd_ok_q;
  logic              game_oob;
  logic              border;

  assign game_oob = bus.game_addr > LAST_ADDR;
  assign border   = (col_q == '0) || (col_q == LAST_COL) || (row_q == LAST_ROW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      video_own_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      video_own_q <= bus.video_en;
      rvalid_q    <= bus.game_ack && !bus.game_we;
      rd_ok_q     <= bus.game_ack && !bus.game_we && !game_oob;
    end
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    addr_d        = addr_q;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.game_ack  = 1'b0;
    bus.game_err  = 1'b0;

    if (bus.video_en) begin
      bus.mem_addr = bus.video_addr;
    end else if (state_q == StInit) begin
      bus.mem_addr  = addr_q;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = border ? DATA_W'(BORDER_VAL) : DATA_W'(AIR_VAL);
      if (addr_q == LAST_ADDR) begin
        state_d = StIdle;
        col_d   = '0;
        row_d   = '0;
        addr_d  = '0;
      end else begin
        // Linear address tracks row*COLS+col incrementally, so no multiply/divide.
        addr_d = addr_q + 1'b1;
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end else if (bus.game_req) begin
      bus.game_ack  = 1'b1;
      bus.game_err  = game_oob;
      bus.mem_addr  = bus.game_addr;
      bus.mem_we    = bus.game_we && !game_oob;
      bus.mem_wdata = bus.game_wdata;
    end

    // A game access may still be acked in this same IDLE cycle.
    if (state_q == StIdle && bus.init_start) begin
      state_d = StInit;
    end
  end

  // RAM data arrives the cycle after the address; steer it to whoever issued that address.
  assign bus.video_data  = video_own_q ? bus.mem_rdata : '0;
  assign bus.game_rdata  = (rvalid_q && rd_ok_q) ? bus.mem_rdata : '0;
  assign bus.game_rvalid = rvalid_q;
  assign bus.init_busy   = (state_q == StInit);

endmodule

// File: tb/tb_grid_mem_arbiter.sv
module tb_grid_mem_arbiter;

  localparam int unsigned NCELLS = 240;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  grid_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  grid_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous read, one-cycle latency.
  logic [7:0] ram [256];
  bit         fill_done = 1'b0;
  always @(posedge clk) begin
    if (!fill_done) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hA5;
      fill_done <= 1'b1;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Write / busy / priority monitor.
  int unsigned wq_addr[$];
  int unsigned wq_data[$];
  int          busy_cycles;
  int          video_we_viol;
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wq_addr.push_back(int'(bus.mem_addr));
      wq_data.push_back(int'(bus.mem_wdata));
      if (bus.video_en) video_we_viol++;
    end
    if (bus.init_busy) busy_cycles++;
  end

  logic [7:0] exp_ram [256];

  function automatic int unsigned img(input int unsigned a);
    int unsigned r, c;
    r = a / 12;
    c = a % 12;
    return (c == 0 || c == 11 || r == 19) ? 8 : 0;
  endfunction

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.video_en   = 1'b0;
    bus.video_addr = '0;
    bus.game_req   = 1'b0;
    bus.game_we    = 1'b0;
    bus.game_addr  = '0;
    bus.game_wdata = '0;
    bus.init_start = 1'b0;
  endtask

  task automatic run_init(input bit rand_video, input string tag);
    int n;
    int bad;
    wq_addr.delete();
    wq_data.delete();
    busy_cycles   = 0;
    video_we_viol = 0;
    bus.init_start = 1'b1;
    step();
    bus.init_start = 1'b0;
    n = 0;
    while (bus.init_busy && n < 2000) begin
      if (rand_video) begin
        bus.video_en   = 1'($urandom % 2);
        bus.video_addr = 8'($urandom_range(0, NCELLS - 1));
      end
      step();
      n++;
    end
    bus.video_en = 1'b0;
    step();
    check_eq({tag, "_done"}, 32'(bus.init_busy), 0);
    check_eq({tag, "_nwrites"}, wq_addr.size(), NCELLS);
    bad = 0;
    for (int i = 0; i < wq_addr.size(); i++)
      if (wq_addr[i] != i || wq_data[i] != img(i)) bad++;
    check_eq({tag, "_order"}, bad, 0);
    check_eq({tag, "_video_we"}, video_we_viol, 0);
    for (int i = 0; i < NCELLS; i++) exp_ram[i] = 8'(img(i));
  endtask

  initial begin
    int n;
    int acks;
    bit exp_rv, exp_vown;
    int unsigned exp_rd, exp_vd;
    bit pend;

    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check_eq("rst_busy", 32'(bus.init_busy), 0);
    check_eq("rst_rvalid", 32'(bus.game_rvalid), 0);
    check_eq("rst_rdata", 32'(bus.game_rdata), 0);
    check_eq("rst_ack", 32'(bus.game_ack), 0);
    check_eq("rst_we", 32'(bus.mem_we), 0);
    check_eq("rst_vdata", 32'(bus.video_data), 0);
    reset = 1'b1;
    step();

    // 1: plain init
    run_init(1'b0, "init");
    check_eq("init_busy_cycles", busy_cycles, NCELLS);
    check_eq("ram0", 32'(ram[0]), 8);
    check_eq("ram13", 32'(ram[13]), 0);
    check_eq("ram22", 32'(ram[22]), 0);
    check_eq("ram23", 32'(ram[23]), 8);
    check_eq("ram239", 32'(ram[239]), 8);

    // 2: init with video stealing cycles
    run_init(1'b1, "init_vid");

    // 3: game write / read, then video read
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 8'd25; bus.game_wdata = 8'd3;
    #1;
    check_eq("gw_ack", 32'(bus.game_ack), 1);
    check_eq("gw_we", 32'(bus.mem_we), 1);
    check_eq("gw_addr", 32'(bus.mem_addr), 25);
    exp_ram[25] = 8'd3;
    step();
    bus.game_we = 1'b0;
    #1;
    check_eq("gr_ack", 32'(bus.game_ack), 1);
    check_eq("gw_no_rvalid", 32'(bus.game_rvalid), 0);
    step();
    bus.game_req = 1'b0;
    check_eq("gr_rvalid", 32'(bus.game_rvalid), 1);
    check_eq("gr_rdata", 32'(bus.game_rdata), 3);
    step();
    check_eq("gr_rvalid_pulse", 32'(bus.game_rvalid), 0);
    bus.video_en = 1'b1; bus.video_addr = 8'd25;
    step();
    bus.video_en = 1'b0;
    check_eq("vid_data", 32'(bus.video_data), 3);

    // 4: game blocked by video
    bus.video_en = 1'b1; bus.video_addr = 8'd7;
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 8'd40;
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.game_ack) acks++;
      step();
    end
    check_eq("blk_acks", acks, 0);
    bus.video_en = 1'b0;
    #1;
    check_eq("blk_release_ack", 32'(bus.game_ack), 1);
    step();
    bus.game_req = 1'b0;
    check_eq("blk_rdata", 32'(bus.game_rdata), 32'(exp_ram[40]));
    step();

    // 5: out-of-range read
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 8'd240;
    #1;
    check_eq("oob_ack", 32'(bus.game_ack), 1);
    check_eq("oob_err", 32'(bus.game_err), 1);
    check_eq("oob_we", 32'(bus.mem_we), 0);
    step();
    bus.game_req = 1'b0;
    check_eq("oob_rvalid", 32'(bus.game_rvalid), 1);
    check_eq("oob_rdata", 32'(bus.game_rdata), 0);
    step();

    // Randomized traffic against the shadow model
    exp_rv = 1'b0; exp_rd = 0; exp_vown = 1'b0; exp_vd = 0; pend = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      check_eq("rnd_rvalid", 32'(bus.game_rvalid), 32'(exp_rv));
      if (exp_rv) check_eq("rnd_rdata", 32'(bus.game_rdata), exp_rd);
      check_eq("rnd_vdata", 32'(bus.video_data), exp_vown ? exp_vd : 0);
      bus.video_en   = ($urandom % 3) == 0;
      bus.video_addr = 8'($urandom_range(0, NCELLS - 1));
      if (!pend && ($urandom % 2) == 1) begin
        pend           = 1'b1;
        bus.game_we    = 1'($urandom % 2);
        bus.game_addr  = ($urandom % 8 == 0) ? 8'($urandom_range(240, 255))
                                             : 8'($urandom_range(0, NCELLS - 1));
        bus.game_wdata = 8'($urandom);
      end
      bus.game_req = pend;
      #1;
      check_eq("rnd_ack", 32'(bus.game_ack), 32'(pend && !bus.video_en));
      exp_vown = bus.video_en;
      exp_vd   = 32'(exp_ram[bus.video_addr]);
      exp_rv   = 1'b0;
      if (pend && !bus.video_en) begin
        check_eq("rnd_err", 32'(bus.game_err), 32'(bus.game_addr >= 8'(NCELLS)));
        if (bus.game_we) begin
          if (bus.game_addr < 8'(NCELLS)) exp_ram[bus.game_addr] = bus.game_wdata;
        end else begin
          exp_rv = 1'b1;
          exp_rd = (bus.game_addr < 8'(NCELLS)) ? 32'(exp_ram[bus.game_addr]) : 0;
        end
        pend = 1'b0;
      end
      step();
    end
    idle_inputs();
    step();

    // 6: reset in the middle of init
    wq_addr.delete();
    bus.init_start = 1'b1;
    step();
    bus.init_start = 1'b0;
    n = 0;
    while (wq_addr.size() < 100 && n < 1000) begin
      step();
      n++;
    end
    check_eq("abort_reached", 32'(wq_addr.size() >= 100), 1);
    check_eq("abort_we_before", 32'(bus.mem_we), 1);
    reset = 1'b0;
    #1;
    check_eq("abort_busy", 32'(bus.init_busy), 0);
    check_eq("abort_we", 32'(bus.mem_we), 0);
    step();
    step();
    reset = 1'b1;
    wq_addr.delete();
    repeat (50) step();
    check_eq("abort_no_writes", wq_addr.size(), 0);
    check_eq("abort_idle", 32'(bus.init_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
